// File: rtl/tm1638_key_event.sv
// tm1638_key_event
//   Debounces the eight raw key levels coming from the TM1638 driver on a slow
//   sample tick. It turns accepted level changes into one-cycle press/release
//   pulses and per-key toggle states. Every accepted edge is also queued as a
//   4-bit event in a show-ahead FIFO that a downstream controller drains with
//   a valid/ready handshake.
//
// Ports
//   CK_i         in   1  core clock
//   ARST_i       in   1  asynchronous reset, active-high; clears all state
//   KEYS_i       in   8  raw key levels (1 = pressed), CK_i domain
//   CLR_i        in   1  synchronous clear of TOGGLE_o and EVT_OVF_o
//   KEYS_STB_o   out  8  debounced key levels
//   PRESS_o      out  8  one-cycle pulse per key on an accepted 0->1
//   RELEASE_o    out  8  one-cycle pulse per key on an accepted 1->0
//   TOGGLE_o     out  8  per-key state, inverted on every accepted press
//   EVT_VALID_o  out  1  event FIFO not empty
//   EVT_DAT_o    out  4  head event {1=press/0=release, key index}, 0 when empty
//   EVT_RDY_i    in   1  consumer ready; an event pops on EVT_VALID_o & EVT_RDY_i
//   EVT_OVF_o    out  1  sticky: an event was dropped on a full FIFO
module tm1638_key_event #(
   parameter int unsigned C_FCK   = 48_000_000,
   parameter int unsigned C_FSMP  = 1_000,
   parameter int unsigned C_DB_N  = 4,
   parameter int unsigned C_DEPTH = 8
) (
   input  logic       CK_i,
   input  logic       ARST_i,
   input  logic [7:0] KEYS_i,
   input  logic       CLR_i,
   output logic [7:0] KEYS_STB_o,
   output logic [7:0] PRESS_o,
   output logic [7:0] RELEASE_o,
   output logic [7:0] TOGGLE_o,
   output logic       EVT_VALID_o,
   output logic [3:0] EVT_DAT_o,
   input  logic       EVT_RDY_i,
   output logic       EVT_OVF_o
);

   localparam int unsigned C_DIV = C_FCK / C_FSMP;
   localparam int unsigned PS_W  = $clog2(C_DIV);
   localparam int unsigned AW    = $clog2(C_DEPTH);

   localparam logic [PS_W-1:0] PS_MAX    = PS_W'(C_DIV - 1);
   localparam logic [3:0]      DB_MAX    = 4'(C_DB_N - 1);
   localparam logic [AW:0]     FIFO_FULL = (AW+1)'(C_DEPTH);

   // ---------------------------------------------------------------
   // Sample-tick prescaler
   // ---------------------------------------------------------------
   logic [PS_W-1:0] ps_q, ps_d;
   logic            tick;

   always_comb begin
      tick = (ps_q == PS_MAX);
      ps_d = tick ? '0 : ps_q + 1'b1;
   end

   // ---------------------------------------------------------------
   // Per-key debounce counters
   // ---------------------------------------------------------------
   logic [7:0] stb_q, stb_d;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_db
         logic [3:0] cnt_q, cnt_d;
         logic       stb_nxt;

         always_comb begin
            cnt_d   = cnt_q;
            stb_nxt = stb_q[gi];
            if (tick) begin
               if (KEYS_i[gi] == stb_q[gi]) begin
                  // any agreeing sample restarts the qualification
                  cnt_d = '0;
               end else if (cnt_q == DB_MAX) begin
                  stb_nxt = ~stb_q[gi];
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end

         assign stb_d[gi] = stb_nxt;

         always_ff @(posedge CK_i or posedge ARST_i) begin
            if (ARST_i) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end
      end
   endgenerate

   // ---------------------------------------------------------------
   // Edge pulses, toggles and the edge serializer
   // ---------------------------------------------------------------
   // The pulses are registered on the same edge that updates stb_q, so
   // PRESS_o/RELEASE_o appear one cycle after the accepting tick.
   logic [7:0] chg;
   logic [7:0] press_q, press_d;
   logic [7:0] release_q, release_d;
   logic [7:0] toggle_q, toggle_d;
   logic [7:0] pend_q, pend_d;
   logic [7:0] ppol_q, ppol_d;
   logic [2:0] sel_idx;
   logic       push;
   logic [3:0] push_dat;

   always_comb begin
      chg       = stb_d ^ stb_q;
      press_d   = chg & stb_d;
      release_d = chg & ~stb_d;
      // a coincident clear overrides the press inversion
      toggle_d  = CLR_i ? 8'h00 : (toggle_q ^ press_d);
   end

   // Lowest pending index wins; at most 8 cycles to drain, which is always
   // shorter than the tick period, so a key never re-triggers while pending.
   always_comb begin
      sel_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (pend_q[i]) begin
            sel_idx = 3'(i);
         end
      end
      push     = |pend_q;
      push_dat = {ppol_q[sel_idx], sel_idx};
      pend_d   = pend_q;
      if (push) begin
         pend_d[sel_idx] = 1'b0;
      end
      pend_d = pend_d | chg;
      ppol_d = (ppol_q & ~chg) | (stb_d & chg);
   end

   // ---------------------------------------------------------------
   // Event FIFO (show-ahead)
   // ---------------------------------------------------------------
   logic [3:0]    mem [C_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          empty, full, pop, wr_en;

   always_comb begin
      empty = (count_q == '0);
      full  = (count_q == FIFO_FULL);
      pop   = ~empty & EVT_RDY_i;
      // a pop in the same cycle frees the slot, so a full FIFO still accepts
      wr_en = push & (~full | pop);

      count_d = count_q;
      if (wr_en & ~pop) begin
         count_d = count_q + 1'b1;
      end else if (~wr_en & pop) begin
         count_d = count_q - 1'b1;
      end

      wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;

      // a drop in the same cycle as CLR_i keeps the flag set
      ovf_d = (push & full & ~pop) | (ovf_q & ~CLR_i);
   end

   // Storage carries no reset: it is only observed through count_q.
   always_ff @(posedge CK_i) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= push_dat;
      end
   end

   // ---------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------
   always_ff @(posedge CK_i or posedge ARST_i) begin
      if (ARST_i) begin
         ps_q      <= '0;
         stb_q     <= '0;
         press_q   <= '0;
         release_q <= '0;
         toggle_q  <= '0;
         pend_q    <= '0;
         ppol_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         ps_q      <= ps_d;
         stb_q     <= stb_d;
         press_q   <= press_d;
         release_q <= release_d;
         toggle_q  <= toggle_d;
         pend_q    <= pend_d;
         ppol_q    <= ppol_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
      end
   end

   assign KEYS_STB_o  = stb_q;
   assign PRESS_o     = press_q;
   assign RELEASE_o   = release_q;
   assign TOGGLE_o    = toggle_q;
   assign EVT_VALID_o = ~empty;
   assign EVT_DAT_o   = empty ? 4'h0 : mem[rd_ptr_q];
   assign EVT_OVF_o   = ovf_q;

endmodule
